id_pipe_stage: RTL

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/id_pipe_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: register file with write-back bypass,
// immediate extension, operand selection and a load-use interlock.
module id_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            ctl_reg_dst,
  input  logic            ctl_reg_wr,
  input  logic            ctl_alu_src,
  input  logic            ctl_ext_op,
  input  logic            ctl_imm_zero,
  input  logic            ctl_mem_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_bus_b,
  output logic [4:0]      out_dst,
  output logic            out_reg_wr,
  output logic            out_mem_rd
);

  localparam int         AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            r_valid;
  logic [XLEN-1:0] r_opA;
  logic [XLEN-1:0] r_opB;
  logic [XLEN-1:0] r_busB;
  logic [4:0]      r_dst;
  logic            r_regWr;
  logic            r_memRd;

  logic [4:0]             w_rs;
  logic [4:0]             w_rt;
  logic [4:0]             w_rd;
  logic                   w_wbWrite;
  logic [XLEN-1:0]        w_rsVal;
  logic [XLEN-1:0]        w_rtVal;
  logic [15:0]            w_imm16;
  logic signed [XLEN-1:0] w_immSext;
  logic [XLEN-1:0]        w_immExt;
  logic [XLEN-1:0]        w_opB;
  logic [4:0]             w_dst;
  logic                   w_advance;
  logic                   w_hazard;

  // Instruction fields use MSB-first numbering: field [6:10] is vector [25:21].
  assign w_rs = instr[25:21];
  assign w_rt = instr[20:16];
  assign w_rd = instr[15:11];

  assign w_wbWrite = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wbWrite) begin
      r_regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // Reads see a same-cycle write-back so the consumer never gets a stale value.
  always_comb begin
    w_rsVal = '0;
    if (w_wbWrite && (wb_addr == w_rs)) begin
      w_rsVal = wb_data;
    end else if ((w_rs != 5'd0) && ({1'b0, w_rs} < NREG)) begin
      w_rsVal = r_regs[w_rs[AW-1:0]];
    end
  end

  always_comb begin
    w_rtVal = '0;
    if (w_wbWrite && (wb_addr == w_rt)) begin
      w_rtVal = wb_data;
    end else if ((w_rt != 5'd0) && ({1'b0, w_rt} < NREG)) begin
      w_rtVal = r_regs[w_rt[AW-1:0]];
    end
  end

  assign w_imm16   = ctl_imm_zero ? 16'h0000 : instr[15:0];
  assign w_immSext = $signed(w_imm16);
  assign w_immExt  = ctl_ext_op ? $unsigned(w_immSext) : XLEN'(w_imm16);
  assign w_opB     = ctl_alu_src ? w_immExt : w_rtVal;
  assign w_dst     = ctl_reg_dst ? w_rd : w_rt;

  // A load still sitting in the output register cannot feed its consumer yet.
  assign w_advance = !r_valid || out_ready;
  assign w_hazard  = r_valid && r_memRd && r_regWr && (r_dst != 5'd0) &&
                     ((r_dst == w_rs) || (r_dst == w_rt));
  assign in_ready  = w_advance && !w_hazard && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_busB  <= '0;
      r_dst   <= '0;
      r_regWr <= 1'b0;
      r_memRd <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_regWr <= 1'b0;
      r_memRd <= 1'b0;
    end else if (w_advance) begin
      if (in_valid && !w_hazard) begin
        r_valid <= 1'b1;
        r_opA   <= w_rsVal;
        r_opB   <= w_opB;
        r_busB  <= w_rtVal;
        r_dst   <= w_dst;
        r_regWr <= ctl_reg_wr;
        r_memRd <= ctl_mem_rd;
      end else begin
        r_valid <= 1'b0;
        r_regWr <= 1'b0;
        r_memRd <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_op_a   = r_opA;
  assign out_op_b   = r_opB;
  assign out_bus_b  = r_busB;
  assign out_dst    = r_dst;
  assign out_reg_wr = r_regWr;
  assign out_mem_rd = r_memRd;

endmodule
